// File: rtl/dmp_cfg_ctrl.sv
// dmp_cfg_ctrl: programming side of the PMP/DMP checker. Holds pmpaddr,
// pmpcfg and dmpcfg entries plus the current domain, serves CSR reads and
// writes, enforces per-entry lock bits, and sequences domain switches so that
// in-flight memory accesses drain before the new domain takes effect.
// Optional feature: define DMP_DOMI_LOCK_EN so that only DOMI code may create
// or modify DOMI-owned dmpcfg entries.

package dmp_cfg_pkg;

  typedef enum logic [1:0] {
    ADDR_OFF   = 2'd0,
    ADDR_TOR   = 2'd1,
    ADDR_NA4   = 2'd2,
    ADDR_NAPOT = 2'd3
  } pmp_addr_mode_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    logic           x;
    logic           w;
    logic           r;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    DOMI = 2'd0,
    DOM0 = 2'd1,
    DOM1 = 2'd2,
    DOM2 = 2'd3
  } dmp_domain_t;

  typedef struct packed {
    dmp_domain_t domain;
  } dmpcfg_t;

endpackage

module dmp_cfg_ctrl
  import dmp_cfg_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CNT_W      = 4,
  localparam int unsigned IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             csr_req_i,
  input  logic                             csr_we_i,
  input  logic [1:0]                       csr_sel_i,
  input  logic [IDX_W-1:0]                 csr_idx_i,
  input  logic [DATA_W-1:0]                csr_wdata_i,
  output logic                             csr_gnt_o,
  output logic                             csr_rvalid_o,
  output logic [DATA_W-1:0]                csr_rdata_o,
  output logic                             csr_err_o,
  input  logic                             acc_issue_i,
  input  logic                             acc_done_i,
  output logic                             stall_o,
  output logic [NR_ENTRIES*PMP_LEN-1:0]    conf_addr_o,
  output pmpcfg_t [NR_ENTRIES-1:0]         pmpconf_o,
  output dmpcfg_t [NR_ENTRIES-1:0]         dmpconf_o,
  output dmp_domain_t                      curdom_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t                                 state_q, state_d;
  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]     addr_q;
  pmpcfg_t [NR_ENTRIES-1:0]               pmpcfg_q;
  dmpcfg_t [NR_ENTRIES-1:0]               dmpcfg_q;
  dmp_domain_t                            curdom_q;
  dmp_domain_t                            pending_q;
  logic [CNT_W-1:0]                       outstanding_q;

  logic                                   gnt;
  logic                                   switch_commit;
  logic                                   wr_entry;
  logic                                   domi_block;
  logic                                   wr_reject;
  logic                                   wr_ok;
  logic                                   sw_req;
  logic [DATA_W-1:0]                      rd_data;
  dmp_domain_t                            new_domain;

  assign new_domain = dmp_domain_t'(csr_wdata_i[1:0]);

  // Request decode: entry writes, lock enforcement, domain-switch requests.
  always_comb begin
    wr_entry   = gnt & csr_we_i & (csr_sel_i != 2'd3);
    sw_req     = gnt & csr_we_i & (csr_sel_i == 2'd3);
    domi_block = 1'b0;
`ifdef DMP_DOMI_LOCK_EN
    domi_block = (csr_sel_i == 2'd2) && (curdom_q != DOMI) &&
                 ((dmpcfg_q[csr_idx_i].domain == DOMI) || (new_domain == DOMI));
`else
    domi_block = 1'b0;
`endif
    wr_reject  = wr_entry & (pmpcfg_q[csr_idx_i].locked | domi_block);
    wr_ok      = wr_entry & ~wr_reject;
  end

  // Read-data mux, zero-extended to the CSR width.
  always_comb begin
    rd_data = '0;
    unique case (csr_sel_i)
      2'd0: rd_data[PMP_LEN-1:0]           = addr_q[csr_idx_i];
      2'd1: rd_data[$bits(pmpcfg_t)-1:0]   = pmpcfg_q[csr_idx_i];
      2'd2: rd_data[$bits(dmpcfg_t)-1:0]   = dmpcfg_q[csr_idx_i];
      default: rd_data[$bits(dmp_domain_t)-1:0] = curdom_q;
    endcase
  end

  // Switch FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Switch FSM next-state and control outputs; CSR is only served in IDLE.
  always_comb begin
    state_d       = state_q;
    gnt           = 1'b0;
    stall_o       = 1'b0;
    switch_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt = csr_req_i;
        if (csr_req_i && csr_we_i && (csr_sel_i == 2'd3)) state_d = DRAIN;
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (outstanding_q == '0) state_d = SWITCH;
      end
      SWITCH: begin
        stall_o       = 1'b1;
        switch_commit = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign csr_gnt_o = gnt;

  // Outstanding memory-access counter, saturating at both ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else if (acc_issue_i && !acc_done_i && (outstanding_q != CNT_MAX)) begin
      outstanding_q <= outstanding_q + 1'b1;
    end else if (acc_done_i && !acc_issue_i && (outstanding_q != '0)) begin
      outstanding_q <= outstanding_q - 1'b1;
    end
  end

  // Entry storage; updated only by accepted writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      pmpcfg_q <= '0;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) dmpcfg_q[i].domain <= DOMI;
    end else if (wr_ok) begin
      unique case (csr_sel_i)
        2'd0:    addr_q[csr_idx_i]          <= csr_wdata_i[PMP_LEN-1:0];
        2'd1:    pmpcfg_q[csr_idx_i]        <= pmpcfg_t'(csr_wdata_i[7:0]);
        default: dmpcfg_q[csr_idx_i].domain <= new_domain;
      endcase
    end
  end

  // Current and pending domain; the switch lands only in the SWITCH cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      curdom_q  <= DOMI;
      pending_q <= DOMI;
    end else begin
      if (sw_req)        pending_q <= new_domain;
      if (switch_commit) curdom_q  <= pending_q;
    end
  end

  // CSR response: one cycle after the grant, or after the switch completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_rvalid_o <= 1'b0;
      csr_err_o    <= 1'b0;
      csr_rdata_o  <= '0;
    end else begin
      csr_rvalid_o <= (gnt & ~sw_req) | switch_commit;
      csr_err_o    <= wr_reject;
      csr_rdata_o  <= (gnt && !csr_we_i) ? rd_data : '0;
    end
  end

  assign conf_addr_o = addr_q;
  assign pmpconf_o   = pmpcfg_q;
  assign dmpconf_o   = dmpcfg_q;
  assign curdom_o    = curdom_q;

endmodule

// File: tb/tb_dmp_cfg_ctrl.sv
// Self-checking bench for dmp_cfg_ctrl: a register-file/queue level model
// predicts every output each cycle, plus literal checks on key scenarios.
// Build with DMP_DOMI_LOCK_EN defined to exercise the DOMI lock feature.

module tb_dmp_cfg_ctrl;

  localparam int N = 16;
  localparam int L = 54;
  localparam int W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              csr_req, csr_we;
  logic [1:0]        csr_sel;
  logic [3:0]        csr_idx;
  logic [W-1:0]      csr_wdata;
  logic              csr_gnt, csr_rvalid, csr_err;
  logic [W-1:0]      csr_rdata;
  logic              acc_issue, acc_done, stall;
  logic [N*L-1:0]    conf_addr;
  logic [N-1:0][7:0] pmpconf;
  logic [N-1:0][1:0] dmpconf;
  logic [1:0]        curdom;

  int checks = 0;
  int errors = 0;

  dmp_cfg_ctrl #(.NR_ENTRIES(N), .PMP_LEN(L), .DATA_W(W), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_req_i(csr_req), .csr_we_i(csr_we), .csr_sel_i(csr_sel),
    .csr_idx_i(csr_idx), .csr_wdata_i(csr_wdata),
    .csr_gnt_o(csr_gnt), .csr_rvalid_o(csr_rvalid), .csr_rdata_o(csr_rdata),
    .csr_err_o(csr_err),
    .acc_issue_i(acc_issue), .acc_done_i(acc_done), .stall_o(stall),
    .conf_addr_o(conf_addr), .pmpconf_o(pmpconf), .dmpconf_o(dmpconf),
    .curdom_o(curdom)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [L-1:0] m_addr [N];
  logic [7:0]   m_cfg  [N];
  logic [1:0]   m_dom  [N];
  logic [1:0]   m_cur, m_pend;
  int           m_cnt;
  bit           m_sw;      // a switch has been requested and not yet applied
  bit           m_ready;   // drain observed empty; switch applies next edge
  bit           m_rv, m_err;
  logic [W-1:0] m_rdata;
  bit           started = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_addr[i] = '0; m_cfg[i] = '0; m_dom[i] = 2'd0;
      end
      m_cur = 2'd0; m_pend = 2'd0; m_cnt = 0; m_sw = 0; m_ready = 0;
      m_rv = 0; m_err = 0; m_rdata = '0;
      started = 1;
    end else begin
      bit g;
      bit rej;
      g = csr_req && !m_sw;
      m_rv = 0; m_err = 0; m_rdata = '0;
      if (m_sw && m_ready) begin
        m_cur = m_pend; m_sw = 0; m_ready = 0; m_rv = 1;
      end else if (m_sw && m_cnt == 0) begin
        m_ready = 1;
      end
      if (acc_issue && !acc_done && m_cnt < 15) m_cnt++;
      else if (acc_done && !acc_issue && m_cnt > 0) m_cnt--;
      if (g) begin
        if (!csr_we) begin
          m_rv = 1;
          case (csr_sel)
            2'd0: m_rdata = W'(m_addr[csr_idx]);
            2'd1: m_rdata = W'(m_cfg[csr_idx]);
            2'd2: m_rdata = W'(m_dom[csr_idx]);
            default: m_rdata = W'(m_cur);
          endcase
        end else if (csr_sel == 2'd3) begin
          m_pend = csr_wdata[1:0];
          m_sw = 1;
        end else begin
          rej = m_cfg[csr_idx][7];
`ifdef DMP_DOMI_LOCK_EN
          if (csr_sel == 2'd2 && m_cur != 2'd0 &&
              (m_dom[csr_idx] == 2'd0 || csr_wdata[1:0] == 2'd0)) rej = 1;
`endif
          m_rv = 1;
          m_err = rej;
          if (!rej) begin
            case (csr_sel)
              2'd0: m_addr[csr_idx] = csr_wdata[L-1:0];
              2'd1: m_cfg[csr_idx]  = csr_wdata[7:0];
              default: m_dom[csr_idx] = csr_wdata[1:0];
            endcase
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", csr_gnt, csr_req && !m_sw);
      chk("rvalid", csr_rvalid, m_rv);
      chk("err", csr_err, m_err);
      chk("rdata", csr_rdata, m_rdata);
      chk("stall", stall, m_sw);
      chk("curdom", curdom, m_cur);
      for (int e = 0; e < N; e++) begin
        chk($sformatf("addr%0d", e), conf_addr[e*L +: L], m_addr[e]);
        chk($sformatf("pmpcfg%0d", e), pmpconf[e], m_cfg[e]);
        chk($sformatf("dmpcfg%0d", e), dmpconf[e], m_dom[e]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit req, input bit we, input logic [1:0] sel,
                      input logic [3:0] idx, input logic [63:0] wd,
                      input bit iss, input bit dn);
    csr_req = req; csr_we = we; csr_sel = sel; csr_idx = idx; csr_wdata = wd;
    acc_issue = iss; acc_done = dn;
    @(posedge clk);
    #1;
    csr_req = 0; csr_we = 0; csr_sel = 0; csr_idx = 0; csr_wdata = '0;
    acc_issue = 0; acc_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 2'd0, 4'd0, 64'd0, 0, 0);
  endtask

  initial begin
    rst = 1; csr_req = 0; csr_we = 0; csr_sel = 0; csr_idx = 0; csr_wdata = '0;
    acc_issue = 0; acc_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_curdom", curdom, 2'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rvalid", csr_rvalid, 1'b0);
    rst = 0;

    // reset readback
    step(1, 0, 2'd2, 4'd0, 64'd0, 0, 0);
    chk("rd_dmp0", csr_rdata, 64'd0);
    chk("rd_rvalid", csr_rvalid, 1'b1);
    idle(1);
    chk("rvalid_one_cycle", csr_rvalid, 1'b0);
    step(1, 0, 2'd3, 4'd0, 64'd0, 0, 0);
    chk("rd_curdom", csr_rdata, 64'd0);
    step(1, 0, 2'd1, 4'd0, 64'd0, 0, 0);
    chk("rd_pmpcfg0", csr_rdata, 64'h00);

    // programming entry 0
    step(1, 1, 2'd0, 4'd0, 64'h19BA >> 2, 0, 0);
    chk("wr_addr0", conf_addr[L-1:0], 64'h66E);
    chk("wr_addr0_err", csr_err, 1'b0);
    step(1, 1, 2'd1, 4'd0, 64'h1F, 0, 0);
    chk("wr_cfg0", pmpconf[0], 8'h1F);
    step(1, 1, 2'd2, 4'd0, 64'd2, 0, 0);
    chk("wr_dmp0", dmpconf[0], 2'd2);
    step(1, 0, 2'd0, 4'd0, 64'd0, 0, 0);
    chk("rb_addr0", csr_rdata, 64'h66E);

    // lock on entry 1
    step(1, 1, 2'd1, 4'd1, 64'h80, 0, 0);
    step(1, 1, 2'd0, 4'd1, 64'h123, 0, 0);
    chk("locked_err", csr_err, 1'b1);
    step(1, 0, 2'd0, 4'd1, 64'd0, 0, 0);
    chk("locked_rb", csr_rdata, 64'd0);
    step(1, 1, 2'd1, 4'd1, 64'h00, 0, 0);
    chk("lock_sticky", pmpconf[1], 8'h80);

    // NA4 accepted as written
    step(1, 1, 2'd1, 4'd2, 64'h13, 0, 0);
    chk("na4_cfg2", pmpconf[2], 8'h13);

    // drain of three accesses, then switch to DOM0
    repeat (3) step(0, 0, 2'd0, 4'd0, 64'd0, 1, 0);
    step(1, 1, 2'd3, 4'd0, 64'd1, 0, 0);
    chk("sw_gnt_no_rvalid", csr_rvalid, 1'b0);
    chk("sw_stall", stall, 1'b1);
    step(1, 0, 2'd0, 4'd0, 64'd0, 0, 0);          // refused while stalled
    step(0, 0, 2'd0, 4'd0, 64'd0, 0, 1);          // 2 left
    step(0, 0, 2'd0, 4'd0, 64'd0, 1, 1);          // still 2
    step(0, 0, 2'd0, 4'd0, 64'd0, 0, 1);          // 1 left
    chk("drain_curdom_old", curdom, 2'd0);
    step(0, 0, 2'd0, 4'd0, 64'd0, 0, 1);          // empty
    chk("drain_still_old", curdom, 2'd0);
    idle(1);
    chk("in_switch_stall", stall, 1'b1);
    chk("in_switch_curdom", curdom, 2'd0);
    idle(1);
    chk("switched_curdom", curdom, 2'd1);
    chk("switched_rvalid", csr_rvalid, 1'b1);
    chk("switched_stall", stall, 1'b0);

    // done at zero, then saturation with 16 issues; 15 dones fully drain
    repeat (2) step(0, 0, 2'd0, 4'd0, 64'd0, 0, 1);
    repeat (16) step(0, 0, 2'd0, 4'd0, 64'd0, 1, 0);
    step(1, 1, 2'd3, 4'd0, 64'd0, 0, 0);
    repeat (15) step(0, 0, 2'd0, 4'd0, 64'd0, 0, 1);
    idle(2);
    chk("sat_switched", curdom, 2'd0);
    chk("sat_stall", stall, 1'b0);

    // DOMI ownership rules
    step(1, 1, 2'd2, 4'd3, 64'd0, 0, 0);
    chk("domi_from_domi_err", csr_err, 1'b0);
    step(1, 1, 2'd3, 4'd0, 64'd1, 0, 0);
    idle(2);
    chk("now_dom0", curdom, 2'd1);
    step(1, 1, 2'd2, 4'd0, 64'd0, 0, 0);
`ifdef DMP_DOMI_LOCK_EN
    chk("create_domi_err", csr_err, 1'b1);
    chk("create_domi_val", dmpconf[0], 2'd2);
`else
    chk("create_domi_err", csr_err, 1'b0);
    chk("create_domi_val", dmpconf[0], 2'd0);
`endif
    step(1, 1, 2'd2, 4'd5, 64'd3, 0, 0);
`ifdef DMP_DOMI_LOCK_EN
    chk("modify_domi_val", dmpconf[5], 2'd0);
`else
    chk("modify_domi_val", dmpconf[5], 2'd3);
`endif
    step(1, 1, 2'd3, 4'd0, 64'd0, 0, 0);
    idle(2);
    step(1, 1, 2'd2, 4'd6, 64'd0, 0, 0);
    chk("domi_ok_err", csr_err, 1'b0);

    // reset in the middle of a switch
    step(0, 0, 2'd0, 4'd0, 64'd0, 1, 0);
    step(1, 1, 2'd3, 4'd0, 64'd3, 0, 0);
    idle(1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_curdom", curdom, 2'd0);
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_cfg0", pmpconf[0], 8'h00);
    rst = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
